// File: rtl/rv_mem_pkg.sv
// ============================================================================
// rv_mem_pkg : size codes, responder FSM states and lane helper functions
// Rev 1.0
// ============================================================================
`default_nettype none

package rv_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_FORM   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic [5:0] lane_shift(input logic [2:0] off);
    return {off, 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_mem_lane.sv
// ============================================================================
// rv_mem_lane : alignment check, store byte-mask/lane shift, load extract/extend
// Rev 1.0
// ============================================================================
`default_nettype none

module rv_mem_lane (
  input  logic [1:0]  i_size,
  input  logic [2:0]  i_offset,
  input  logic        i_signed,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rword,
  output logic        o_err,
  output logic [7:0]  o_bmask,
  output logic [63:0] o_wdata_sh,
  output logic [63:0] o_rdata
);
  import rv_mem_pkg::*;

  logic [63:0] w_rsh;

  assign o_err      = is_misaligned(i_size, i_offset);
  assign o_bmask    = byte_mask(i_size, i_offset);
  assign o_wdata_sh = i_wdata << lane_shift(i_offset);
  assign w_rsh      = i_rword >> lane_shift(i_offset);

  always_comb begin
    o_rdata = w_rsh;
    case (i_size)
      SZ_B:    o_rdata = {{56{i_signed & w_rsh[7]}},  w_rsh[7:0]};
      SZ_H:    o_rdata = {{48{i_signed & w_rsh[15]}}, w_rsh[15:0]};
      SZ_W:    o_rdata = {{32{i_signed & w_rsh[31]}}, w_rsh[31:0]};
      default: o_rdata = w_rsh;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv_dmem_resp.sv
// ============================================================================
// rv_dmem_resp : stalling data-memory responder on a valid/ready load/store port
// Rev 1.0
// ============================================================================
`default_nettype none

module rv_dmem_resp #(
  parameter int AW   = 12,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_signed_i,
  input  logic [63:0]   req_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [63:0]   rsp_rdata_o,
  output logic          rsp_err_o
);
  import rv_mem_pkg::*;

  localparam int         c_depth     = 2 ** (AW - 3);
  localparam logic [3:0] c_wait_last = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [63:0]   r_rdata;
  logic          r_err;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [63:0]   r_wdata;
  logic [63:0]   r_rword;
  logic [63:0]   r_mem [c_depth];

  logic [AW-4:0] w_idx;
  logic          w_err;
  logic [7:0]    w_bmask;
  logic [63:0]   w_wdata_sh;
  logic [63:0]   w_rdata;

  assign w_idx = r_addr[AW-1:3];

  rv_mem_lane u_lane (
    .i_size     (r_size),
    .i_offset   (r_addr[2:0]),
    .i_signed   (r_signed),
    .i_wdata    (r_wdata),
    .i_rword    (r_rword),
    .o_err      (w_err),
    .o_bmask    (w_bmask),
    .o_wdata_sh (w_wdata_sh),
    .o_rdata    (w_rdata)
  );

  // Storage is read synchronously in ACCESS; FORM then steers the registered word.
  always_ff @(posedge clk) begin
    if (!rst && r_state == ST_ACCESS) begin
      r_rword <= r_mem[w_idx];
      if (r_we && !w_err) begin
        for (int b = 0; b < 8; b++) begin
          if (w_bmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 64'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i && r_req_ready) begin
            r_we        <= req_we_i;
            r_addr      <= req_addr_i;
            r_size      <= req_size_i;
            r_signed    <= req_signed_i;
            r_wdata     <= req_wdata_i;
            r_req_ready <= 1'b0;
            r_cnt       <= 4'd0;
            r_state     <= (WAIT > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (r_cnt == c_wait_last) r_state <= ST_ACCESS;
          else                      r_cnt   <= r_cnt + 4'd1;
        end
        ST_ACCESS: r_state <= ST_FORM;
        ST_FORM: begin
          r_rsp_valid <= 1'b1;
          r_err       <= w_err;
          r_rdata     <= (r_we || w_err) ? 64'd0 : w_rdata;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rv_dmem_resp.sv
// ============================================================================
// tb_rv_dmem_resp : directed table + randomized checks for WAIT=2 and WAIT=0 builds
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rv_dmem_resp;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [11:0] req_addr   [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [63:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [63:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int n_vec = 0;
  int n_mis = 0;

  // Byte-addressed reference image of each responder's storage
  logic [7:0] mdl [2][4096];

  rv_dmem_resp #(.AW(12), .WAIT(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_size_i(req_size[0]), .req_signed_i(req_signed[0]),
    .req_wdata_i(req_wdata[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  rv_dmem_resp #(.AW(12), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_size_i(req_size[1]), .req_signed_i(req_signed[1]),
    .req_wdata_i(req_wdata[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] wdata;
    int          hold;
    logic [63:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [64:0] mdl_load(input int sel, input logic [11:0] a,
                                           input logic [1:0] sz, input logic sgn);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = 64'd0;
    if ((int'(a) % n) != 0) return {1'b1, 64'd0};
    for (int i = 0; i < n; i++) v = v | (64'(mdl[sel][int'(a) + i]) << (8 * i));
    if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return {1'b0, v};
  endfunction

  task automatic mdl_store(input int sel, input logic [11:0] a, input logic [1:0] sz,
                           input logic [63:0] wd);
    int n;
    n = 1 << sz;
    if ((int'(a) % n) == 0)
      for (int i = 0; i < n; i++) mdl[sel][int'(a) + i] = 8'(wd >> (8 * i));
  endtask

  task automatic do_txn(input int sel, input logic we, input logic [11:0] addr,
                        input logic [1:0] sz, input logic sgn, input logic [63:0] wd,
                        input int hold, input string tag,
                        input logic [63:0] exp_d, input logic exp_e);
    int   lat;
    bit   got;
    bit   busy_ok;
    bit   stable_ok;
    logic [63:0] d0;
    logic e0;
    @(negedge clk);
    req_we[sel] = we; req_addr[sel] = addr; req_size[sel] = sz;
    req_signed[sel] = sgn; req_wdata[sel] = wd; req_valid[sel] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[sel]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk({tag, " accept-timeout"}, 64'd0, 64'd1);
      req_valid[sel] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Accepted: drop valid and scramble fields, which must now be ignored
    req_valid[sel] = 1'b0;
    req_addr[sel] = 12'($urandom); req_wdata[sel] = {$urandom, $urandom};
    req_size[sel] = 2'($urandom); req_we[sel] = 1'($urandom); req_signed[sel] = 1'($urandom);
    lat = 0; got = 1'b0; busy_ok = 1'b1;
    while (lat <= 20) begin
      if (rsp_valid[sel]) begin got = 1'b1; break; end
      if (req_ready[sel]) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), (sel == 0) ? 64'd4 : 64'd2);
    if (!got) return;
    chk({tag, " ready-low-while-busy"}, 64'(busy_ok), 64'd1);
    chk({tag, " rdata"}, rsp_rdata[sel], exp_d);
    chk({tag, " err"}, 64'(rsp_err[sel]), 64'(exp_e));
    d0 = rsp_rdata[sel]; e0 = rsp_err[sel]; stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!rsp_valid[sel] || rsp_rdata[sel] !== d0 || rsp_err[sel] !== e0 || req_ready[sel])
        stable_ok = 1'b0;
    end
    if (hold > 0) chk({tag, " stable-while-stalled"}, 64'(stable_ok), 64'd1);
    rsp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[sel] = 1'b0;
    chk({tag, " ready-after-handshake"}, {62'd0, req_ready[sel], rsp_valid[sel]}, 64'd2);
  endtask

  task automatic run_op(input int sel, input logic we, input logic [11:0] addr,
                        input logic [1:0] sz, input logic sgn, input logic [63:0] wd,
                        input int hold, input string tag);
    logic [64:0] e;
    if (we) e = {((int'(addr) % (1 << sz)) != 0), 64'd0};
    else    e = mdl_load(sel, addr, sz, sgn);
    do_txn(sel, we, addr, sz, sgn, wd, hold, tag, e[63:0], e[64]);
    if (we) mdl_store(sel, addr, sz, wd);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 12'h010, 2'd3, 1'b0, 64'h1122334455667788, 0, 64'h0, 1'b0};
    tbl[1]  = '{1'b0, 12'h010, 2'd3, 1'b0, 64'h0, 5, 64'h1122334455667788, 1'b0};
    tbl[2]  = '{1'b1, 12'h013, 2'd0, 1'b0, 64'hDEADBEEF000000AB, 0, 64'h0, 1'b0};
    tbl[3]  = '{1'b0, 12'h013, 2'd0, 1'b1, 64'h0, 0, 64'hFFFFFFFFFFFFFFAB, 1'b0};
    tbl[4]  = '{1'b0, 12'h010, 2'd3, 1'b0, 64'h0, 0, 64'h11223344AB667788, 1'b0};
    tbl[5]  = '{1'b1, 12'h011, 2'd1, 1'b0, 64'h000000000000BEEF, 2, 64'h0, 1'b1};
    tbl[6]  = '{1'b0, 12'h010, 2'd3, 1'b0, 64'h0, 0, 64'h11223344AB667788, 1'b0};
    tbl[7]  = '{1'b0, 12'h012, 2'd1, 1'b0, 64'h0, 0, 64'h000000000000AB66, 1'b0};
    tbl[8]  = '{1'b0, 12'h012, 2'd1, 1'b1, 64'h0, 0, 64'hFFFFFFFFFFFFAB66, 1'b0};
    tbl[9]  = '{1'b1, 12'h014, 2'd2, 1'b0, 64'h12345678CAFEF00D, 0, 64'h0, 1'b0};
    tbl[10] = '{1'b0, 12'h014, 2'd2, 1'b1, 64'h0, 0, 64'hFFFFFFFFCAFEF00D, 1'b0};
    tbl[11] = '{1'b0, 12'h010, 2'd3, 1'b1, 64'h0, 0, 64'hCAFEF00DAB667788, 1'b0};
    tbl[12] = '{1'b0, 12'h012, 2'd2, 1'b0, 64'h0, 0, 64'h0, 1'b1};
    tbl[13] = '{1'b0, 12'h017, 2'd0, 1'b0, 64'h0, 0, 64'h00000000000000CA, 1'b0};

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = 12'd0; req_size[s] = 2'd0;
      req_signed[s] = 1'b0; req_wdata[s] = 64'd0; rsp_ready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset%0d ready/valid/err", s),
          {61'd0, req_ready[s], rsp_valid[s], rsp_err[s]}, 64'd4);
      chk($sformatf("reset%0d rdata", s), rsp_rdata[s], 64'd0);
    end

    for (int i = 0; i < 14; i++) begin
      do_txn(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].sgn, tbl[i].wdata,
             tbl[i].hold, $sformatf("tbl[%0d]", i), tbl[i].exp_d, tbl[i].exp_e);
      if (tbl[i].we) mdl_store(0, tbl[i].addr, tbl[i].size, tbl[i].wdata);
    end

    // Zero-stall build: word store then signed word load
    do_txn(1, 1'b1, 12'h008, 2'd2, 1'b0, 64'h0000000080000000, 0, "w0 store", 64'h0, 1'b0);
    mdl_store(1, 12'h008, 2'd2, 64'h0000000080000000);
    do_txn(1, 1'b0, 12'h008, 2'd2, 1'b1, 64'h0, 0, "w0 load", 64'hFFFFFFFF80000000, 1'b0);

    // Reset during the stall of a store: no write, outputs back to reset values
    do_txn(0, 1'b1, 12'h020, 2'd3, 1'b0, 64'h0123456789ABCDEF, 0, "pre-rst store", 64'h0, 1'b0);
    mdl_store(0, 12'h020, 2'd3, 64'h0123456789ABCDEF);
    @(negedge clk);
    req_we[0] = 1'b1; req_addr[0] = 12'h020; req_size[0] = 2'd3;
    req_wdata[0] = 64'hFFFFFFFFFFFFFFFF; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst ready/valid/err", {61'd0, req_ready[0], rsp_valid[0], rsp_err[0]}, 64'd4);
    chk("midrst rdata", rsp_rdata[0], 64'd0);
    rst = 1'b0;
    do_txn(0, 1'b0, 12'h020, 2'd3, 1'b0, 64'h0, 0, "post-rst load", 64'h0123456789ABCDEF, 1'b0);

    // Randomized traffic against the byte-image model, over a fully initialized window
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 32; w++)
        run_op(s, 1'b1, 12'(w * 8), 2'd3, 1'b0, {$urandom, $urandom}, 0,
               $sformatf("init%0d[%0d]", s, w));
      for (int k = 0; k < 150; k++)
        run_op(s, 1'($urandom), 12'($urandom_range(0, 255)), 2'($urandom), 1'($urandom),
               {$urandom, $urandom}, int'($urandom_range(0, 2)), $sformatf("rnd%0d[%0d]", s, k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
